cdb_writeback_arbiter: RTL and testbench
========================================

# cdb_writeback_arbiter

Shares one common-data-bus writeback lane among up to NUM_REQ functional units (ALU, MUL, BR, MEM). Each unit pushes finished results into a private result FIFO; every cycle the arbiter broadcasts the oldest buffered result by program-order tag. The broadcast lane feeds the CDB consumed by the reservation stations and the ROB. Flushes drop all buffered results.

## Interface
- NUM_REQ, 4, number of requesting functional units (≥2)
- BUF_DEPTH, 2, result FIFO entries per requester (power of 2, ≥2)
- DATA_WIDTH, 32, result width
- ROB_IDX_WIDTH, 5, ROB index width
- ORDER_WIDTH, 64, program-order tag width (smaller = older)
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; synchronous clear, same effect as rst
- req_valid  in  NUM_REQ  per-unit result valid
- req_ready  out  NUM_REQ  per-unit FIFO can accept
- req_data  in  NUM_REQ×DATA_WIDTH  result data
- req_rd_addr  in  NUM_REQ×5  destination arch register
- req_rob_idx  in  NUM_REQ×ROB_IDX_WIDTH  ROB index of result
- req_order  in  NUM_REQ×ORDER_WIDTH  program-order tag
- wb_ready  in  1  CDB consumer accepts broadcast this cycle
- wb_valid  out  1  broadcast valid
- wb_data  out  DATA_WIDTH  broadcast data
- wb_rd_addr  out  5  broadcast destination register
- wb_rob_idx  out  ROB_IDX_WIDTH  broadcast ROB index
- wb_src  out  $clog2(NUM_REQ)  index of granted unit

## Operation
- Per unit: circular FIFO with head/tail pointers ($clog2(BUF_DEPTH) bits, natural wrap) and count ($clog2(BUF_DEPTH)+1 bits).
- Push: req_valid[i] && req_ready[i] writes entry at tail[i], tail+1, count+1.
- req_ready[i] = (count[i] < BUF_DEPTH) && !flush; depends on registered count only, no same-cycle pop bypass.
- Selection (combinational): among units with count>0, pick the head entry with the smallest req_order; equal tags go to the lowest index. wb_valid = any count>0 && !flush; wb_* = the selected head; wb_src = its index.
- Pop: wb_valid && wb_ready removes the selected head (head+1, count−1). At most one pop per cycle.
- Push and pop on the same unit in one cycle: count unchanged, both pointers advance.
- wb_ready low: outputs hold, nothing popped. A newly pushed older entry on another unit may displace the current selection next cycle (no lock-in).
- rd_addr = 0 is still broadcast; the ROB needs completion.
- flush or rst: all heads, tails and counts → 0; pushes in that cycle are dropped; no pop.

## Timing
- Reset values: wb_valid=0, wb_data=0, wb_rd_addr=0, wb_rob_idx=0, wb_src=0, req_ready=all 1s (the cycle after rst deasserts; 0 while rst/flush is high).
- Latency: a result pushed at edge N is broadcast in cycle N+1 at the earliest; it pops at the first edge where it is selected and wb_ready=1.
- Throughput: one broadcast per cycle. Each unit sustains one push per cycle while its FIFO drains.
- Full FIFO: req_ready[i]=0 for the whole cycle even if the same-cycle pop frees a slot; it reasserts the following cycle.
- Empty: wb_valid=0 and wb_* are don't-care (driven 0).
- Flush mid-stall: buffered results are gone the next cycle; wb_valid=0 in the flush cycle itself.

## Test plan
- Single push: unit 1 pushes {data=0xDEADBEEF, rob=3, order=10} at cycle 0, wb_ready=1 → cycle 1: wb_valid=1, wb_src=1, wb_data=0xDEADBEEF, wb_rob_idx=3; cycle 2: wb_valid=0.
- Age ordering: units 0/2/3 push orders 30/10/20 in the same cycle → broadcasts over the next 3 cycles are src 2, 3, 0.
- Backpressure/full: wb_ready=0, unit 0 pushes 3 times with BUF_DEPTH=2 → req_ready[0]=0 after 2 pushes, third transfer not accepted; raise wb_ready → both entries drain in FIFO order and req_ready[0] returns to 1.
- Pointer wrap: unit 3 streams 10 results (orders 0..9), one per cycle, with wb_ready=1 → 10 consecutive broadcasts in order, no gaps after the first, no loss.
- Flush: 2 entries in unit 1, 1 in unit 2, wb_ready=0, assert flush for 1 cycle with a simultaneous push on unit 0 → next cycle wb_valid=0, all req_ready=1, the dropped push never appears.
- Reset mid-operation: FIFOs partially full, assert rst → all outputs at reset values the next cycle; a subsequent single push behaves as in scenario 1.

Source files
------------

// File: rtl/cdb_writeback_arbiter_if.sv
// Writeback bus between the functional units / CDB consumer and the arbiter.
// Per-unit request fields are packed flat, unit i in slice [i*W +: W].
interface cdb_writeback_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROB_IDX_WIDTH = 5,
    parameter int unsigned ORDER_WIDTH   = 64
);
    localparam int unsigned RD_W  = 5;
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ*RD_W-1:0]          req_rd_addr;
    logic [NUM_REQ*ROB_IDX_WIDTH-1:0] req_rob_idx;
    logic [NUM_REQ*ORDER_WIDTH-1:0]   req_order;

    logic                     wb_ready;
    logic                     wb_valid;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic [RD_W-1:0]          wb_rd_addr;
    logic [ROB_IDX_WIDTH-1:0] wb_rob_idx;
    logic [SRC_W-1:0]         wb_src;

    // Functional units and CDB consumer side
    modport master (
        output req_valid, req_data, req_rd_addr, req_rob_idx, req_order, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_rd_addr, wb_rob_idx, wb_src
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_rd_addr, req_rob_idx, req_order, wb_ready,
        output req_ready, wb_valid, wb_data, wb_rd_addr, wb_rob_idx, wb_src
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// One CDB writeback lane shared by NUM_REQ units: per-unit result FIFOs,
// oldest-head-first selection by program-order tag, one broadcast per cycle.
module cdb_writeback_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned BUF_DEPTH     = 2,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROB_IDX_WIDTH = 5,
    parameter int unsigned ORDER_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    cdb_writeback_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RD_W  = 5;

    logic [PTR_W-1:0]         r_head  [NUM_REQ];
    logic [PTR_W-1:0]         r_tail  [NUM_REQ];
    logic [CNT_W-1:0]         r_count [NUM_REQ];

    logic [DATA_WIDTH-1:0]    r_data  [NUM_REQ][BUF_DEPTH];
    logic [RD_W-1:0]          r_rd    [NUM_REQ][BUF_DEPTH];
    logic [ROB_IDX_WIDTH-1:0] r_rob   [NUM_REQ][BUF_DEPTH];
    logic [ORDER_WIDTH-1:0]   r_order [NUM_REQ][BUF_DEPTH];

    logic [NUM_REQ-1:0]       w_ready;
    logic [NUM_REQ-1:0]       w_push;
    logic [NUM_REQ-1:0]       w_pop;

    logic [DATA_WIDTH-1:0]    w_head_data  [NUM_REQ];
    logic [RD_W-1:0]          w_head_rd    [NUM_REQ];
    logic [ROB_IDX_WIDTH-1:0] w_head_rob   [NUM_REQ];
    logic [ORDER_WIDTH-1:0]   w_head_order [NUM_REQ];

    logic                     w_any;
    logic [SRC_W-1:0]         w_sel;
    logic [ORDER_WIDTH-1:0]   w_best;
    logic                     w_wb_valid;

    // Ready looks only at the registered count: a same-cycle pop never frees a slot early
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i]      = (r_count[i] < CNT_W'(BUF_DEPTH)) && !flush && !rst;
            w_push[i]       = bus.req_valid[i] && w_ready[i];
            w_head_data[i]  = r_data[i][r_head[i]];
            w_head_rd[i]    = r_rd[i][r_head[i]];
            w_head_rob[i]   = r_rob[i][r_head[i]];
            w_head_order[i] = r_order[i][r_head[i]];
        end
    end

    // Oldest non-empty head wins; strict compare keeps ties on the lowest index
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_best = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_count[i] != '0) begin
                if (!w_any || (w_head_order[i] < w_best)) begin
                    w_any  = 1'b1;
                    w_sel  = SRC_W'(i);
                    w_best = w_head_order[i];
                end
            end
        end
    end

    always_comb begin
        w_wb_valid = w_any && !flush && !rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pop[i] = w_wb_valid && bus.wb_ready && (w_sel == SRC_W'(i));
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.wb_valid   = w_wb_valid;
    assign bus.wb_data    = w_wb_valid ? w_head_data[w_sel] : '0;
    assign bus.wb_rd_addr = w_wb_valid ? w_head_rd[w_sel]   : '0;
    assign bus.wb_rob_idx = w_wb_valid ? w_head_rob[w_sel]  : '0;
    assign bus.wb_src     = w_wb_valid ? w_sel              : '0;

    // Payload storage needs no reset; only pointers and counts define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_push[i]) begin
                r_data[i][r_tail[i]]  <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                r_rd[i][r_tail[i]]    <= bus.req_rd_addr[i*RD_W +: RD_W];
                r_rob[i][r_tail[i]]   <= bus.req_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                r_order[i][r_tail[i]] <= bus.req_order[i*ORDER_WIDTH +: ORDER_WIDTH];
            end
        end
    end

    // Pointer and occupancy tracking; flush clears exactly like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_push[i]) begin
                    r_tail[i] <= r_tail[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_head[i] <= r_head[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_count[i] <= r_count[i] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed vector table, hand sequences and
// random traffic checked against a queue-based reference model.
module tb_cdb_writeback_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned BD = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic [63:0] order;
    } entry_t;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            wbr;
        logic [3:0]      v;
        logic [3:0][7:0] ord;
        logic            e_valid;
        logic [1:0]      e_src;
        logic [7:0]      e_ord;
        logic [3:0]      e_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    cdb_writeback_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(32), .ROB_IDX_WIDTH(5), .ORDER_WIDTH(64)) bus ();

    cdb_writeback_arbiter #(
        .NUM_REQ(NR), .BUF_DEPTH(BD), .DATA_WIDTH(32), .ROB_IDX_WIDTH(5), .ORDER_WIDTH(64)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err    = 0;
    logic   drv_rst, drv_flush, drv_wbr;
    logic [3:0] drv_v;
    entry_t drv_e [NR];
    entry_t mq [NR][$];
    vec_t   tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] pdata(input int u, input logic [7:0] o);
        return 32'hC0DE_0000 | (32'(u) << 8) | 32'(o);
    endfunction
    function automatic logic [4:0] prob(input int u, input logic [7:0] o);
        return 5'(o) + 5'(3 * u);
    endfunction
    function automatic logic [4:0] prd(input int u, input logic [7:0] o);
        return 5'(o) ^ 5'(u);
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic w, input logic [3:0] v,
                                input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2,
                                input logic [7:0] o3, input logic ev, input logic [1:0] es,
                                input logic [7:0] eo, input logic [3:0] er);
        vec_t t;
        t.rst = r; t.flush = f; t.wbr = w; t.v = v;
        t.ord[0] = o0; t.ord[1] = o1; t.ord[2] = o2; t.ord[3] = o3;
        t.e_valid = ev; t.e_src = es; t.e_ord = eo; t.e_ready = er;
        return t;
    endfunction

    task automatic apply();
        rst          = drv_rst;
        flush        = drv_flush;
        bus.wb_ready = drv_wbr;
        bus.req_valid = drv_v;
        for (int u = 0; u < NR; u++) begin
            bus.req_data[u*32 +: 32]   = drv_e[u].data;
            bus.req_rd_addr[u*5 +: 5]  = drv_e[u].rd;
            bus.req_rob_idx[u*5 +: 5]  = drv_e[u].rob;
            bus.req_order[u*64 +: 64]  = drv_e[u].order;
        end
    endtask

    task automatic idle_inputs();
        drv_rst = 1'b0; drv_flush = 1'b0; drv_wbr = 1'b1; drv_v = '0;
        for (int u = 0; u < NR; u++) drv_e[u] = '0;
    endtask

    // Compare DUT with the queue model for the current cycle, then advance one edge
    task automatic model_step();
        logic        mv;
        int          ms;
        logic [63:0] mo;
        logic [3:0]  er;
        entry_t      he;
        mv = 1'b0; ms = 0; mo = '0; he = '0;
        for (int i = 0; i < NR; i++) begin
            er[i] = !drv_rst && !drv_flush && (mq[i].size() < BD);
            if (!drv_rst && !drv_flush && mq[i].size() > 0) begin
                if (!mv || mq[i][0].order < mo) begin
                    mv = 1'b1; ms = i; mo = mq[i][0].order;
                end
            end
        end
        if (mv) he = mq[ms][0];
        chk("model ready",  64'(bus.req_ready),  64'(er));
        chk("model valid",  64'(bus.wb_valid),   64'(mv));
        chk("model src",    64'(bus.wb_src),     mv ? 64'(ms) : 64'd0);
        chk("model data",   64'(bus.wb_data),    64'(he.data));
        chk("model rd",     64'(bus.wb_rd_addr), 64'(he.rd));
        chk("model rob",    64'(bus.wb_rob_idx), 64'(he.rob));
        if (drv_rst || drv_flush) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
        end else begin
            if (mv && drv_wbr) void'(mq[ms].pop_front());
            for (int i = 0; i < NR; i++) begin
                if (drv_v[i] && er[i]) mq[i].push_back(drv_e[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        drv_rst = 1'b1;
        apply();

        //        rst   flush wbr  valid    o0     o1     o2     o3     ev    es    eo     ready
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b1101, 8'd30, 8'd0,  8'd10, 8'd20, 1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd2, 8'd10, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd3, 8'd20, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd30, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        // backpressure fills unit 0; third push refused, ready stays low during the freeing pop
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 8'd40, 8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 8'd41, 8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd40, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 8'd42, 8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd40, 4'b1110));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0001, 8'd42, 8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd40, 4'b1110));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd41, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        // stalled selection displaced by an older push, then a tie resolved to the lower index
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0100, 8'd0,  8'd0,  8'd50, 8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0010, 8'd0,  8'd45, 8'd0,  8'd0,  1'b1, 2'd2, 8'd50, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd1, 8'd45, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 8'd0,  8'd0,  8'd0,  8'd45, 1'b1, 2'd1, 8'd45, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd1, 8'd45, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd3, 8'd45, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd2, 8'd50, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        // flush while stalled, with a push on unit 0 that must be dropped
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0110, 8'd0,  8'd60, 8'd70, 8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0010, 8'd0,  8'd61, 8'd0,  8'd0,  1'b1, 2'd1, 8'd60, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd1, 8'd60, 4'b1101));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0001, 8'd5,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));
        // reset with entries buffered
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 8'd80, 8'd0,  8'd0,  8'd81, 1'b0, 2'd0, 8'd0,  4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b1, 2'd0, 8'd80, 4'b1111));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 2'd0, 8'd0,  4'b1111));

        #1;
        foreach (tbl[k]) begin
            drv_rst = tbl[k].rst; drv_flush = tbl[k].flush; drv_wbr = tbl[k].wbr; drv_v = tbl[k].v;
            for (int u = 0; u < NR; u++) begin
                drv_e[u].data  = pdata(u, tbl[k].ord[u]);
                drv_e[u].rd    = prd(u, tbl[k].ord[u]);
                drv_e[u].rob   = prob(u, tbl[k].ord[u]);
                drv_e[u].order = 64'(tbl[k].ord[u]);
            end
            apply();
            #2;
            chk($sformatf("tbl%0d valid", k), 64'(bus.wb_valid), 64'(tbl[k].e_valid));
            chk($sformatf("tbl%0d ready", k), 64'(bus.req_ready), 64'(tbl[k].e_ready));
            chk($sformatf("tbl%0d src", k),   64'(bus.wb_src),    64'(tbl[k].e_src));
            chk($sformatf("tbl%0d data", k),  64'(bus.wb_data),
                tbl[k].e_valid ? 64'(pdata(int'(tbl[k].e_src), tbl[k].e_ord)) : 64'd0);
            chk($sformatf("tbl%0d rob", k),   64'(bus.wb_rob_idx),
                tbl[k].e_valid ? 64'(prob(int'(tbl[k].e_src), tbl[k].e_ord)) : 64'd0);
            model_step();
        end

        // single push on unit 1 after the reset above
        idle_inputs();
        drv_v = 4'b0010;
        drv_e[1] = '{data: 32'hDEAD_BEEF, rd: 5'd7, rob: 5'd3, order: 64'd10};
        apply(); #2;
        chk("single push cycle0 valid", 64'(bus.wb_valid), 64'd0);
        model_step();
        idle_inputs(); apply(); #2;
        chk("single valid", 64'(bus.wb_valid),   64'd1);
        chk("single src",   64'(bus.wb_src),     64'd1);
        chk("single data",  64'(bus.wb_data),    64'hDEAD_BEEF);
        chk("single rob",   64'(bus.wb_rob_idx), 64'd3);
        model_step();
        apply(); #2;
        chk("single drained", 64'(bus.wb_valid), 64'd0);
        model_step();

        // unit 3 streams ten results, forcing pointer wrap with push and pop each cycle
        for (int k = 0; k <= 10; k++) begin
            idle_inputs();
            if (k < 10) begin
                drv_v = 4'b1000;
                drv_e[3] = '{data: 32'h0000_1000 + 32'(k), rd: 5'(k), rob: 5'(k + 1), order: 64'(k)};
            end
            apply(); #2;
            chk($sformatf("wrap%0d valid", k), 64'(bus.wb_valid), (k == 0) ? 64'd0 : 64'd1);
            if (k > 0) begin
                chk($sformatf("wrap%0d src", k),  64'(bus.wb_src),  64'd3);
                chk($sformatf("wrap%0d data", k), 64'(bus.wb_data), 64'h0000_1000 + 64'(k - 1));
            end
            model_step();
        end

        // random traffic against the model; narrow order range makes ties common
        for (int c = 0; c < 3000; c++) begin
            drv_rst   = ($urandom_range(0, 99) == 0);
            drv_flush = ($urandom_range(0, 39) == 0);
            drv_wbr   = ($urandom_range(0, 9) < 6);
            for (int u = 0; u < NR; u++) begin
                drv_v[u]       = 1'($urandom_range(0, 1));
                drv_e[u].data  = $urandom;
                drv_e[u].rd    = 5'($urandom_range(0, 31));
                drv_e[u].rob   = 5'($urandom_range(0, 31));
                drv_e[u].order = 64'($urandom_range(0, 15));
            end
            apply(); #2;
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
